// File: rtl/load_store_unit.sv
// Load/store unit: sequences RV32I loads and stores onto a word-wide data memory.
// Byte and halfword stores use a read-modify-write pair so other lanes are preserved.
module load_store_unit #(
   parameter int ADDR_BITS = 13
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic        resp_err,
   output logic [31:0] resp_rdata,
   output logic        dm_mem_write,
   output logic        dm_mem_read,
   output logic [2:0]  dm_funct3,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_write_data,
   input  logic [31:0] dm_read_data
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_STORE  = 3'd2;
   localparam logic [2:0] S_RMW_RD = 3'd3;
   localparam logic [2:0] S_RMW_WR = 3'd4;
   localparam logic [2:0] S_RESP   = 3'd5;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   logic [2:0]  state_q, state_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] merge_q, merge_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;

   // Unsupported codes, store-only illegal codes, misalignment and out-of-range addresses.
   function automatic logic req_bad(input logic wr, input logic [2:0] f3,
                                    input logic [31:0] a);
      logic bad;
      bad = 1'b0;
      case (f3)
         F3_B:    bad = 1'b0;
         F3_H:    bad = a[0];
         F3_W:    bad = (a[1:0] != 2'b00);
         F3_BU:   bad = wr;
         F3_HU:   bad = wr | a[0];
         default: bad = 1'b1;
      endcase
      if ((a >> ADDR_BITS) != 32'd0) bad = 1'b1;
      return bad;
   endfunction

   function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] word);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (lo)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lo[1] ? word[31:16] : word[15:0];
      case (f3)
         F3_B:    r = {{24{b[7]}}, b};
         F3_BU:   r = {24'd0, b};
         F3_H:    r = {{16{h[15]}}, h};
         F3_HU:   r = {16'd0, h};
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] lo,
                                               input logic [31:0] old, input logic [15:0] wd);
      logic [31:0] r;
      r = old;
      if (f3 == F3_H) begin
         if (lo[1]) r[31:16] = wd;
         else       r[15:0]  = wd;
      end else begin
         case (lo)
            2'd0:    r[7:0]   = wd[7:0];
            2'd1:    r[15:8]  = wd[7:0];
            2'd2:    r[23:16] = wd[7:0];
            default: r[31:24] = wd[7:0];
         endcase
      end
      return r;
   endfunction

   always_comb begin
      state_d      = state_q;
      funct3_d     = funct3_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      merge_d      = merge_q;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               funct3_d = req_funct3;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               if (req_bad(req_write, req_funct3, req_addr)) begin
                  state_d      = S_RESP;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = 32'd0;
               end else if (!req_write) begin
                  state_d = S_LOAD;
               end else if (req_funct3 == F3_W) begin
                  state_d = S_STORE;
               end else begin
                  state_d = S_RMW_RD;
               end
            end
         end
         S_LOAD: begin
            resp_rdata_d = load_extend(funct3_q, addr_q[1:0], dm_read_data);
            resp_err_d   = 1'b0;
            state_d      = S_RESP;
         end
         S_RMW_RD: begin
            merge_d = dm_read_data;
            state_d = S_RMW_WR;
         end
         S_STORE, S_RMW_WR: begin
            resp_rdata_d = 32'd0;
            resp_err_d   = 1'b0;
            state_d      = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Response fields update only on the edge entering RESP, so they hold between responses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         funct3_q     <= 3'd0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         merge_q      <= 32'd0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         funct3_q     <= funct3_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         merge_q      <= merge_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
      end
   end

   always_comb begin
      dm_mem_read   = (state_q == S_LOAD)  || (state_q == S_RMW_RD);
      dm_mem_write  = (state_q == S_STORE) || (state_q == S_RMW_WR);
      dm_write_data = 32'd0;
      if (state_q == S_STORE)
         dm_write_data = wdata_q;
      else if (state_q == S_RMW_WR)
         dm_write_data = store_merge(funct3_q, addr_q[1:0], merge_q, wdata_q[15:0]);
   end

   assign req_ready  = (state_q == S_IDLE);
   assign resp_valid = (state_q == S_RESP);
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign dm_funct3  = F3_W;
   assign dm_addr    = {addr_q[31:2], 2'b00};

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: ADDR_BITS, 13, count of low byte-address bits backed by data memory; any set bit at or above this position is out of range.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports: req_valid input 1 request strobe; req_write input 1 (1=store, 0=load); req_funct3 input 3 RV32I width/sign code; req_addr input 32 byte address; req_wdata input 32 store data in low bits.
REQ-005 SHALL have ports: req_ready output 1 (high only in IDLE); resp_valid output 1 one-cycle completion pulse; resp_err output 1 request rejected; resp_rdata output 32 extended load result.
REQ-006 SHALL have ports: dm_mem_write output 1; dm_mem_read output 1; dm_funct3 output 3; dm_addr output 32; dm_write_data output 32; dm_read_data input 32 (combinational word read, valid in the same cycle).

Function
REQ-007 SHALL implement states IDLE, LOAD, STORE, RMW_RD, RMW_WR, RESP; one state per cycle, no waits.
REQ-008 SHALL accept a request on the rising edge where state==IDLE and req_valid==1, latching funct3, addr and wdata; req_* is ignored in all other states.
REQ-009 SHALL reject with resp_err=1, no memory access, IDLE->RESP, for: funct3 011/110/111; store funct3 100/101; lh/lhu/sh with addr[0]=1; lw/sw with addr[1:0]!=0; addr bits [31:ADDR_BITS] nonzero.
REQ-010 SHALL route valid requests from IDLE: loads->LOAD; sw->STORE; sb/sh->RMW_RD.
REQ-011 SHALL, in LOAD and RMW_RD, drive dm_mem_read=1; in STORE and RMW_WR, dm_mem_write=1; in every other state both 0.
REQ-012 SHALL drive dm_funct3=010 and dm_addr={addr[31:2],2'b00} at all times (latched addr).
REQ-013 SHALL, in LOAD, capture on the clock edge: lb sign-extend, lbu zero-extend byte addr[1:0] (lane 0 = bits 7:0); lh sign-extend, lhu zero-extend halfword addr[1]; lw whole word -> resp_rdata; next state RESP.
REQ-014 SHALL, in RMW_RD, capture dm_read_data into an internal merge word; next state RMW_WR.
REQ-015 SHALL, in RMW_WR, drive dm_write_data = merge word with byte lane addr[1:0] (sb) or halfword lane addr[1] (sh) replaced by wdata[7:0]/wdata[15:0]; other lanes unchanged; next state RESP.
REQ-016 SHALL, in STORE, drive dm_write_data=wdata; next state RESP; dm_write_data SHALL be 0 outside STORE/RMW_WR.
REQ-017 SHALL assert resp_valid for exactly the RESP cycle, then return to IDLE; resp_err and resp_rdata SHALL hold until the next RESP.
REQ-018 SHALL clear resp_rdata to 0 on store and error responses.
REQ-019 SHALL meet latency (cycles from accept edge to resp_valid high): error 1, lw/lb/lbu/lh/lhu 2, sw 2, sb/sh 3; throughput one request per latency+1 cycles.

Reset
REQ-020 SHALL on rst=1 immediately force state IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, dm_mem_read=0, dm_mem_write=0, dm_write_data=0, latched registers 0.
REQ-021 SHALL abandon any in-flight request on reset with no memory write if rst rises before the RMW_WR/STORE clock edge; no response is produced for it.
REQ-022 SHALL accept a request on the first rising edge after rst falls.

Verification
REQ-023 SHALL cover: memory word 0 = 0x000000F7; lb addr 0 -> resp_rdata 0xFFFFFFF7 two cycles after accept; lbu addr 0 -> 0x000000F7.
REQ-024 SHALL cover: word 1 = 0x11223344; sb addr 6 data 0xAA -> one read then one write of 0x11AA3344 at dm_addr 4; resp_valid 3 cycles after accept; lw addr 4 then returns 0x11AA3344.
REQ-025 SHALL cover: sh addr 0x0A data 0x0000BEEF over word 2 = 0 -> write 0xBEEF0000; lh addr 0x0A -> 0xFFFFBEEF; lhu -> 0x0000BEEF.
REQ-026 SHALL cover: lw addr 0x3, sh addr 0x1, sw addr 0x2000, funct3 011 -> each resp_err=1 one cycle after accept, dm_mem_read and dm_mem_write never asserted.
REQ-027 SHALL cover: sb in RMW_RD, rst pulsed asynchronously mid-cycle -> dm strobes drop immediately, target word unchanged, no resp_valid, req_ready=1.
REQ-028 SHALL cover: req_valid held high with back-to-back lw requests -> accepts only in IDLE, one resp_valid per request, no request lost or duplicated.
